alu_32b_seq: RTL
================

# alu_32b_seq

Registered 32-bit ALU stage that consumes the combinational bitwise and arithmetic units (`xor_32b`, `and_32b`, `or_32b`, `nor_32b`, adder/subtractor, `slt`) and contains the sequential shift-add multiplier. It latches operands on a start pulse and selects the unit output by opcode. Single-cycle operations complete in one clock; multiply completes in 32 clocks. Results are presented with a one-cycle `done` pulse to the downstream register/writeback stage.

## Interface
- `WIDTH`, default 32: operand and result width. The multiplier counter is sized `clog2(WIDTH)+1`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request pulse. Sampled only in IDLE.
- `alu_op` input 3: opcode.
  - 000 add
  - 001 xor
  - 010 sub
  - 011 mult
  - 100 slt
  - 101 nor
  - 110 and
  - 111 or
- `i0` input WIDTH: operand A.
- `i1` input WIDTH: operand B.
- `result` output WIDTH: registered result. For mult it holds the low word of the product.
- `result_hi` output WIDTH: high word of the product. Updated only by mult; holds its value otherwise.
- `zero` output 1: registered; high when `result` == 0.
- `overflow` output 1: registered; signed overflow for add/sub; 0 for all other ops.
- `busy` output 1: high while a multiply is in progress.
- `done` output 1: one-cycle pulse when `result` becomes valid.

## Operation
- FSM states: IDLE, MUL.
- **IDLE, start=1, op≠011:**
  - Compute from `i0`/`i1` and register the result into `result`, `zero`, `overflow`.
  - Assert `done` the next cycle.
  - Stay in IDLE.
- **IDLE, start=1, op=011:**
  - Load multiplicand ← `i0`.
  - Load the 2·WIDTH+1 product register: low half ← `i1`, upper bits ← 0.
  - Counter ← 0. Go to MUL. `busy`=1.
- **MUL, each cycle:**
  - If product LSB is 1, add the multiplicand to the upper WIDTH bits, keeping the carry in the extra bit.
  - Then shift the whole product register right by 1.
  - Increment the counter.
- **MUL, counter reaching WIDTH-1:**
  - On this cycle's edge write the final product: `result` ← low word, `result_hi` ← high word.
  - Update `zero` from the low word; `overflow` ← 0.
  - Pulse `done`, drop `busy`, return to IDLE.
- Multiply is unsigned; the full 2·WIDTH product is exact.
- sub is `i0 + ~i1 + 1`.
- overflow:
  - add: operands have equal sign and the sum sign differs.
  - sub: operands have different signs and the result sign differs from `i0`.
- slt is signed: `result` = {31'b0, (`i0` < `i1` signed)}. Its overflow flag is 0.
- Operands are captured at the start edge. Changes to `i0`/`i1`/`alu_op` during MUL have no effect.
- `start` while `busy`=1 is ignored: no queueing, no extra `done`.
- `start` held high in IDLE issues one operation per cycle for single-cycle ops. Each gets its own `done`.
- After a mult completes, a `start` in the first IDLE cycle is accepted normally.

## Timing
- Reset values: `result`=0, `result_hi`=0, `zero`=1, `overflow`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset mid-multiply aborts it: next cycle all outputs are at reset values and no `done` is issued.
- Reset wins over a simultaneous `start`.
- Single-cycle op: `start` sampled at edge E0. Then `result`/`zero`/`overflow` are valid and `done`=1 during the cycle after E0. `done` falls at E1 unless a new op is sampled at E1.
- Mult: `start` sampled at E0. `busy`=1 after E0. Iterations happen at E1..E32. Result is valid, `done`=1 and `busy`=0 after E32, i.e. latency 32 cycles for WIDTH=32.
- `result` and `result_hi` remain stable between `done` pulses.

## Test plan
- xor, `i0`=0x00000000, `i1`=0xFFFFFFFF:
  - `result`=0xFFFFFFFF, `zero`=0.
  - `done` high exactly one cycle after start.
  - Repeat with equal operands → `result`=0, `zero`=1.
- add 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `overflow`=1.
- sub 5 − 7 → `result`=0xFFFFFFFE, `overflow`=0.
- slt with `i0`=0xFFFFFFFF, `i1`=1 → `result`=1.
- mult 0xFFFFFFFF × 0xFFFFFFFF:
  - `busy` high for 32 cycles.
  - `done` at cycle 32 after start.
  - `result_hi`=0xFFFFFFFE, `result`=0x00000001.
- mult 0x00012345 × 0x00000010:
  - `result`=0x00123450, `result_hi`=0.
  - A second `start` (xor) issued at cycle 10 is ignored: exactly one `done`, no change to the result.
- Mult with `reset` asserted at cycle 15:
  - Next cycle shows `busy`=0, `result`=0, `zero`=1, `done`=0.
  - A fresh xor issued afterwards completes in 1 cycle with the correct value.

Source files
------------

// File: rtl/alu_32b_seq.sv
`default_nettype none
// ============================================================================
// alu_32b_seq : registered 32-bit ALU stage with a sequential shift-add multiplier
// Revision    : 1.0
// ============================================================================

module alu_32b_units #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sum_ovf;
    logic             diff_ovf;
    logic             lt;

    assign sum      = a + b;
    assign diff     = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt       = $signed(a) < $signed(b);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                ovf = sum_ovf;
            end
            OP_SUB: begin
                res = diff;
                ovf = diff_ovf;
            end
            OP_XOR: res = a ^ b;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR: res = ~(a | b);
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            default: res = '0;
        endcase
    end
endmodule

module alu_32b_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int         CW      = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MULT = 3'b011;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH:0]   prod_step;
    logic               last_iter;
    logic               accept;
    logic [WIDTH-1:0]   unit_res;
    logic               unit_ovf;

    alu_32b_units #(.WIDTH(WIDTH)) u_units (
        .a   (i0),
        .b   (i1),
        .op  (alu_op),
        .res (unit_res),
        .ovf (unit_ovf)
    );

    // One shift-add step: conditional add into the upper half (carry kept in
    // the extra top bit), then shift the whole register right by one.
    assign partial   = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {1'b0, partial, prod[WIDTH-1:1]};
    assign last_iter = (count == CW'(WIDTH - 1));
    assign accept    = (state == IDLE) && start;
    assign busy      = (state == MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (alu_op == OP_MULT)) state_next = MUL;
            MUL:  if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            prod      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (alu_op == OP_MULT) begin
                    mcand <= i0;
                    prod  <= {{(WIDTH+1){1'b0}}, i1};
                    count <= '0;
                end else begin
                    result   <= unit_res;
                    zero     <= (unit_res == '0);
                    overflow <= unit_ovf;
                    done     <= 1'b1;
                end
            end else if (state == MUL) begin
                prod  <= prod_step;
                count <= count + CW'(1);
                if (last_iter) begin
                    result    <= prod_step[WIDTH-1:0];
                    result_hi <= prod_step[2*WIDTH-1:WIDTH];
                    zero      <= (prod_step[WIDTH-1:0] == '0);
                    overflow  <= 1'b0;
                    done      <= 1'b1;
                    count     <= '0;
                end
            end
        end
    end
endmodule
`default_nettype wire
